// File: rtl/am_lock_rx.sv
// am_lock_rx: 40GBASE-R receive alignment marker lock for one PCS lane, with 1-cycle block pass-through
//   clk, reset (async, active-high)
//   block_lock_i           lane block lock from block sync
//   valid_i, head_i, data_i incoming 66-bit block (byte 0 in data_i[7:0])
//   valid_o, head_o, data_o block registered by one cycle
//   marker_v_o             output block is an alignment marker to be stripped
//   am_lock_o, lane_o      marker lock and logical lane id of the locked marker
//   bip_err_o              BIP3 mismatch pulse, only built with AM_BIP_CHECK_EN defined
module am_lock_rx #(
    parameter int LANE_N    = 4,
    parameter int HEAD_W    = 2,
    parameter int DATA_W    = 64,
    parameter int GAP_W     = 14,
    parameter int INVLD_MAX = 4,
    parameter int LANE_W    = (LANE_N > 1) ? $clog2(LANE_N) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              block_lock_i,
    input  logic              valid_i,
    input  logic [HEAD_W-1:0] head_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [HEAD_W-1:0] head_o,
    output logic [DATA_W-1:0] data_o,
    output logic              marker_v_o,
    output logic              am_lock_o,
    output logic [LANE_W-1:0] lane_o,
    output logic              bip_err_o
);
    localparam int INV_W = $clog2(INVLD_MAX + 1);

    typedef enum logic [1:0] {FIND, CONFIRM, LOCKED} state_t;

    state_t            state_q, state_n;
    logic [GAP_W-1:0]  cnt_q, cnt_n;
    logic [INV_W-1:0]  invld_q, invld_n;
    logic [LANE_W-1:0] lane_q, lane_n, first_idx;
    logic [LANE_N-1:0] match;
    logic              any_match, expect_am, lane_match, mark_n;

    // Fixed marker bytes packed as {byte6, byte5, byte4, byte2, byte1, byte0}; BIP bytes 3 and 7 excluded
    function automatic logic [47:0] am_pat(input int idx);
        case (idx)
            0:       am_pat = {8'hB8, 8'h89, 8'h6F, 8'h47, 8'h76, 8'h90};
            1:       am_pat = {8'h19, 8'h3B, 8'h0F, 8'hE6, 8'hC4, 8'hF0};
            2:       am_pat = {8'h64, 8'h9A, 8'h3A, 8'h9B, 8'h65, 8'hC5};
            3:       am_pat = {8'hC2, 8'h86, 8'h5D, 8'h3D, 8'h79, 8'hA2};
            default: am_pat = '0;
        endcase
    endfunction

    for (genvar i = 0; i < LANE_N; i++) begin : g_match
        assign match[i] = head_i == HEAD_W'(1) && {data_i[55:32], data_i[23:0]} == am_pat(i);
    end

    // Lowest matching index wins
    always_comb begin
        first_idx = '0;
        for (int k = LANE_N - 1; k >= 0; k--)
            if (match[k]) first_idx = LANE_W'(k);
    end

    assign any_match  = |match;
    assign lane_match = match[lane_q];
    assign expect_am  = &cnt_q;

    // The counter is not forced to zero at expected positions: it is all-ones there and wraps to zero anyway
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        invld_n = invld_q;
        lane_n  = lane_q;
        mark_n  = 1'b0;
        if (!block_lock_i) begin
            state_n = FIND;
            cnt_n   = '0;
            invld_n = '0;
            lane_n  = '0;
        end else if (valid_i) begin
            cnt_n = cnt_q + 1'b1;
            case (state_q)
                FIND: if (any_match) begin
                    state_n = CONFIRM;
                    lane_n  = first_idx;
                    cnt_n   = '0;
                    mark_n  = 1'b1;
                end
                CONFIRM: if (expect_am) begin
                    mark_n  = 1'b1;
                    invld_n = '0;
                    state_n = lane_match ? LOCKED : FIND;
                end
                LOCKED: if (expect_am) begin
                    mark_n = 1'b1;
                    if (lane_match) invld_n = '0;
                    else if (invld_q == INV_W'(INVLD_MAX - 1)) begin
                        state_n = FIND;
                        invld_n = '0;
                    end else invld_n = invld_q + 1'b1;
                end
                default: state_n = FIND;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FIND;
            cnt_q      <= '0;
            invld_q    <= '0;
            lane_q     <= '0;
            valid_o    <= 1'b0;
            head_o     <= '0;
            data_o     <= '0;
            marker_v_o <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            invld_q    <= invld_n;
            lane_q     <= lane_n;
            valid_o    <= valid_i;
            head_o     <= head_i;
            data_o     <= data_i;
            marker_v_o <= mark_n;
        end
    end

    assign am_lock_o = state_q == LOCKED;
    assign lane_o    = lane_q;

`ifdef AM_BIP_CHECK_EN
    logic [7:0]               acc_q, blk_bip;
    logic [HEAD_W+DATA_W-1:0] vec;

    assign vec = {data_i, head_i};

    always_comb begin
        blk_bip = '0;
        for (int k = 0; k < HEAD_W + DATA_W; k++) blk_bip[k % 8] = blk_bip[k % 8] ^ vec[k];
    end

    // Accumulator spans one marker (inclusive) to the next (exclusive), then reloads with the new marker
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q     <= '0;
            bip_err_o <= 1'b0;
        end else begin
            if (valid_i) acc_q <= mark_n ? blk_bip : acc_q ^ blk_bip;
            bip_err_o <= mark_n && state_q == LOCKED && lane_match && acc_q != data_i[31:24];
        end
    end
`else
    assign bip_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_am_lock_rx.sv
// tb_am_lock_rx: randomized scoreboard bench for am_lock_rx against a block-level reference model
module tb_am_lock_rx;
    localparam int GAP  = 6;
    localparam int P    = 1 << GAP;
    localparam int IMAX = 4;
`ifdef AM_BIP_CHECK_EN
    localparam bit BIP_EN = 1'b1;
`else
    localparam bit BIP_EN = 1'b0;
`endif
    localparam logic [7:0] PAT [4][6] = '{
        '{8'h90, 8'h76, 8'h47, 8'h6F, 8'h89, 8'hB8},
        '{8'hF0, 8'hC4, 8'hE6, 8'h0F, 8'h3B, 8'h19},
        '{8'hC5, 8'h65, 8'h9B, 8'h3A, 8'h9A, 8'h64},
        '{8'hA2, 8'h79, 8'h3D, 8'h5D, 8'h86, 8'hC2}};

    logic        clk = 1'b0, reset = 1'b1, block_lock_i = 1'b0, valid_i = 1'b0;
    logic [1:0]  head_i = '0;
    logic [63:0] data_i = '0;
    logic        valid_o, marker_v_o, am_lock_o, bip_err_o;
    logic [1:0]  head_o, lane_o;
    logic [63:0] data_o;

    am_lock_rx #(.GAP_W(GAP), .INVLD_MAX(IMAX)) dut (
        .clk(clk), .reset(reset), .block_lock_i(block_lock_i), .valid_i(valid_i),
        .head_i(head_i), .data_i(data_i), .valid_o(valid_o), .head_o(head_o),
        .data_o(data_o), .marker_v_o(marker_v_o), .am_lock_o(am_lock_o),
        .lane_o(lane_o), .bip_err_o(bip_err_o));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  head;
        logic [63:0] data;
        logic        mark;
        logic        lock;
        logic [1:0]  lane;
        logic        bip;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0;

    int         m_mode = 0, m_since = 0, m_lane = 0, m_bad = 0;
    logic [7:0] m_acc = '0;

    function automatic int am_lane(input logic [1:0] h, input logic [63:0] d);
        for (int l = 0; l < 4; l++) begin
            bit ok = h == 2'b01;
            for (int b = 0; b < 6; b++)
                if (d[8*(b < 3 ? b : b + 1) +: 8] != PAT[l][b]) ok = 0;
            if (ok) return l;
        end
        return -1;
    endfunction

    function automatic logic [7:0] bip(input logic [1:0] h, input logic [63:0] d);
        logic [71:0] v = {6'b0, d, h};
        logic [7:0]  r = '0;
        for (int i = 0; i < 9; i++) r ^= v[8*i +: 8];
        return r;
    endfunction

    task automatic model(input logic v, input logic bl, input logic [1:0] h, input logic [63:0] d);
        exp_t e;
        int   hit;
        bit   mark = 0, berr = 0;
        if (!bl) begin
            m_mode = 0; m_since = 0; m_bad = 0; m_lane = 0;
        end else if (v) begin
            hit = am_lane(h, d);
            m_since++;
            if (m_mode == 0) begin
                if (hit >= 0) begin m_mode = 1; m_lane = hit; m_since = 0; mark = 1; end
            end else if (m_since % P == 0) begin
                mark = 1;
                if (m_mode == 1) m_mode = (hit == m_lane) ? 2 : 0;
                else if (hit == m_lane) begin berr = m_acc != d[31:24]; m_bad = 0; end
                else begin
                    m_bad++;
                    if (m_bad == IMAX) begin m_mode = 0; m_bad = 0; end
                end
            end
        end
        if (v) begin
            e.head = h; e.data = d; e.mark = mark; e.lock = m_mode == 2;
            e.lane = 2'(m_lane); e.bip = berr & BIP_EN;
            q.push_back(e);
            m_acc = mark ? bip(h, d) : m_acc ^ bip(h, d);
        end
    endtask

    task automatic drive(input logic v, input logic bl, input logic [1:0] h, input logic [63:0] d);
        @(negedge clk);
        valid_i = v; block_lock_i = bl; head_i = h; data_i = d;
        model(v, bl, h, d);
    endtask

    task automatic pay(input int n, input int vprob);
        int sent = 0;
        while (sent < n) begin
            logic v = $urandom_range(99) < vprob;
            drive(v, 1'b1, $urandom_range(1) ? 2'b01 : 2'b10, {$urandom, $urandom});
            if (v) sent++;
        end
    endtask

    // kind 0: good marker, 1: corrupted pattern byte, 2: good pattern with wrong BIP3
    task automatic am(input int lane, input int kind);
        logic [63:0] d = {$urandom, $urandom};
        for (int b = 0; b < 6; b++) d[8*(b < 3 ? b : b + 1) +: 8] = PAT[lane][b];
        d[31:24] = m_acc ^ {7'b0, kind == 2};
        if (kind == 1) d[7:0] ^= 8'h01;
        drive(1'b1, 1'b1, 2'b01, d);
    endtask

    task automatic frame(input int lane, input int kind, input int vprob);
        am(lane, kind);
        pay(P - 1, vprob);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && valid_o) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got block %h_%h with empty scoreboard", head_o, data_o);
                end else begin
                    e = q.pop_front();
                    if ({head_o, data_o, marker_v_o, am_lock_o, lane_o, bip_err_o} !== e) begin
                        errors++;
                        $display("FAIL block_out: got h=%h d=%h mk=%b lk=%b ln=%0d be=%b expected h=%h d=%h mk=%b lk=%b ln=%0d be=%b",
                                 head_o, data_o, marker_v_o, am_lock_o, lane_o, bip_err_o,
                                 e.head, e.data, e.mark, e.lock, e.lane, e.bip);
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {valid_o, marker_v_o, am_lock_o, lane_o, bip_err_o, head_o, data_o}, '0);
        reset = 1'b0;
        pay(5, 100);
        frame(2, 0, 100);
        chk("confirm_no_lock", am_lock_o, 0);
        chk("confirm_lane", lane_o, 2);
        frame(2, 0, 100);
        frame(2, 0, 100);
        chk("lock_l2", am_lock_o, 1);
        chk("lane_l2", lane_o, 2);
        drive(1'b1, 1'b0, 2'b10, {$urandom, $urandom});
        pay(3, 100);
        chk("drop_lock", am_lock_o, 0);
        chk("drop_lane", lane_o, 0);
        frame(2, 0, 100);
        frame(1, 0, 100);
        chk("wrong_lane_confirm", am_lock_o, 0);
        frame(1, 0, 100);
        chk("l1_first", am_lock_o, 0);
        frame(1, 0, 100);
        chk("lock_l1", am_lock_o, 1);
        chk("lane_l1", lane_o, 1);
        drive(1'b1, 1'b0, 2'b10, {$urandom, $urandom});
        frame(0, 0, 100);
        frame(0, 0, 100);
        chk("lock_l0", am_lock_o, 1);
        repeat (3) frame(0, 1, 100);
        frame(0, 0, 100);
        chk("three_bad_hold", am_lock_o, 1);
        repeat (3) frame(0, 1, 100);
        chk("three_bad_again", am_lock_o, 1);
        frame(0, 1, 100);
        chk("four_bad_drop", am_lock_o, 0);
        frame(0, 0, 100);
        frame(0, 0, 100);
        chk("relock_l0", am_lock_o, 1);
        repeat (3) frame(0, 0, 50);
        chk("gappy_valid_lock", am_lock_o, 1);
        frame(0, 2, 100);
        frame(0, 0, 100);
        frame(0, 0, 70);
        chk("bip_lock_held", am_lock_o, 1);
        am(0, 0);
        pay(10, 100);
        @(posedge clk);
        #2;
        chk("pre_reset_lock", am_lock_o, 1);
        reset = 1'b1;
        #1;
        chk("async_reset", {valid_o, marker_v_o, am_lock_o, lane_o, bip_err_o, head_o, data_o}, '0);
        m_mode = 0; m_since = 0; m_lane = 0; m_bad = 0; m_acc = '0;
        @(negedge clk);
        valid_i = 1'b0;
        reset = 1'b0;
        frame(3, 0, 100);
        frame(3, 0, 100);
        chk("lock_l3", am_lock_o, 1);
        chk("lane_l3", lane_o, 3);
        drive(1'b0, 1'b1, 2'b00, '0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
